// File: rtl/lv8_pkg.sv
// Shared LEGv8 pipeline definitions used by fetch, control and hazard logic.
package lv8_pkg;

  localparam int unsigned ADDR_W     = 64;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned PC_INC     = 4;
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 21;
  localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2,
    S_FULL = 2'd3
  } fetch_state_e;

  // Opcode field extraction for a full-width instruction word
  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register: valid bit plus instruction and its address.
module if_id_reg #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned ADDR_W  = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [ADDR_W-1:0]  d_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc
);

  // Flush wins over load; otherwise contents hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= d_instr;
      pc    <= d_pc;
    end
  end

endmodule

// File: rtl/if_stage.sv
// LEGv8 instruction-fetch stage: PC, req/ready fetch port, skid buffer, IF/ID.
module if_stage #(
  parameter int unsigned       ADDR_W   = lv8_pkg::ADDR_W,
  parameter int unsigned       INSTR_W  = lv8_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [10:0]        ifid_opcode
);

  import lv8_pkg::*;

  fetch_state_e       state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  redir;
  logic [ADDR_W-1:0]  skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  tgt;
  logic [ADDR_W-1:0]  pc_next_seq;

  logic               ld;
  logic               fl;
  logic [INSTR_W-1:0] d_instr;
  logic [ADDR_W-1:0]  d_pc;

  // Branch targets are word aligned; low bits forced to zero
  assign tgt         = branch_target & ~ADDR_W'(3);
  assign pc_next_seq = pc + ADDR_W'(PC_INC);
  assign imem_addr   = pc;
  assign ifid_opcode = ifid_instr[OPCODE_MSB:OPCODE_LSB];

  // Fetch sequencer: PC, redirect, skid buffer and request line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      redir      <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
      imem_req   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (branch_taken) pc <= tgt;
          state    <= S_REQ;
          imem_req <= 1'b1;
        end
        S_REQ: begin
          if (branch_taken) begin
            if (imem_ready) begin
              pc <= tgt;
            end else begin
              redir <= tgt;
              state <= S_DROP;
            end
          end else if (imem_ready) begin
            pc <= pc_next_seq;
            if (stall && ifid_valid) begin
              skid_instr <= imem_rdata;
              skid_pc    <= pc;
              state      <= S_FULL;
              imem_req   <= 1'b0;
            end
          end
        end
        S_DROP: begin
          // Address must not move until the abandoned request completes
          if (branch_taken) redir <= tgt;
          if (imem_ready) begin
            pc    <= branch_taken ? tgt : redir;
            state <= S_REQ;
          end
        end
        S_FULL: begin
          if (branch_taken) begin
            skid_instr <= '0;
            skid_pc    <= '0;
            pc         <= tgt;
            state      <= S_REQ;
            imem_req   <= 1'b1;
          end else if (!stall) begin
            state    <= S_REQ;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID load/flush decode and data source select (memory or skid)
  always_comb begin
    ld      = 1'b0;
    fl      = 1'b0;
    d_instr = imem_rdata;
    d_pc    = pc;
    case (state)
      S_IDLE: fl = branch_taken;
      S_REQ: begin
        if (branch_taken)                          fl = 1'b1;
        else if (imem_ready && (!stall || !ifid_valid)) ld = 1'b1;
      end
      S_DROP: fl = branch_taken;
      S_FULL: begin
        if (branch_taken) begin
          fl = 1'b1;
        end else if (!stall) begin
          ld      = 1'b1;
          d_instr = skid_instr;
          d_pc    = skid_pc;
        end
      end
      default: fl = 1'b1;
    endcase
  end

  if_id_reg #(
    .INSTR_W(INSTR_W),
    .ADDR_W (ADDR_W)
  ) u_if_id (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (ld),
    .flush  (fl),
    .d_instr(d_instr),
    .d_pc   (d_pc),
    .valid  (ifid_valid),
    .instr  (ifid_instr),
    .pc     (ifid_pc)
  );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, reset corner, random vs model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [63:0] ifid_pc;
  logic [10:0] ifid_opcode;

  int checks   = 0;
  int failures = 0;

  if_stage #(.ADDR_W(64), .INSTR_W(32), .RESET_PC(64'h0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .ifid_valid   (ifid_valid),
    .ifid_instr   (ifid_instr),
    .ifid_pc      (ifid_pc),
    .ifid_opcode  (ifid_opcode)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Instruction word the directed memory returns for an address
  function automatic logic [31:0] rd_of(input logic [63:0] a);
    return {a[10:0], 5'h15, a[15:0]};
  endfunction

  typedef struct {
    logic        rdy;
    logic        st;
    logic        br;
    logic [63:0] tgt;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_v;
    logic [63:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  // Reference model state (transaction view of the fetch stage)
  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } pkt_t;

  bit          m_started;
  bit          m_dropping;
  logic [63:0] m_redir;
  logic [63:0] m_pc;
  bit          m_v;
  pkt_t        m_ifid;
  pkt_t        m_skid[$];

  task automatic model_reset();
    m_started  = 0;
    m_dropping = 0;
    m_redir    = '0;
    m_pc       = 64'h0;
    m_v        = 0;
    m_ifid     = '{instr: '0, pc: '0};
    m_skid.delete();
  endtask

  task automatic model_step(input bit br, input logic [63:0] tg, input bit rdy,
                            input logic [31:0] rd, input bit st);
    logic [63:0] t;
    pkt_t p;
    t = {tg[63:2], 2'b00};
    if (!m_started) begin
      m_started = 1;
      if (br) begin m_pc = t; m_v = 0; end
    end else if (m_skid.size() != 0) begin
      if (br) begin
        m_skid.delete();
        m_v  = 0;
        m_pc = t;
      end else if (!st) begin
        m_ifid = m_skid.pop_front();
        m_v    = 1;
      end
    end else if (m_dropping) begin
      if (br) begin m_redir = t; m_v = 0; end
      if (rdy) begin
        m_pc       = m_redir;
        m_dropping = 0;
      end
    end else begin
      if (br) begin
        m_v = 0;
        if (rdy) m_pc = t;
        else begin m_redir = t; m_dropping = 1; end
      end else if (rdy) begin
        p.instr = rd;
        p.pc    = m_pc;
        if (!st || !m_v) begin m_ifid = p; m_v = 1; end
        else m_skid.push_back(p);
        m_pc = m_pc + 64'd4;
      end
    end
  endtask

  initial begin
    logic [31:0] exp_instr;
    logic [10:0] exp_op;
    rst_n = 1'b0;
    imem_ready = 1'b0; imem_rdata = '0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0;

    // rdy st br tgt | req addr v pc
    tbl.push_back('{1,0,0,64'h0,   1,64'h0,   0,64'h0});
    tbl.push_back('{1,0,0,64'h0,   1,64'h4,   1,64'h0});
    tbl.push_back('{1,0,0,64'h0,   1,64'h8,   1,64'h4});
    tbl.push_back('{0,0,0,64'h0,   1,64'h8,   1,64'h4});
    tbl.push_back('{0,0,0,64'h0,   1,64'h8,   1,64'h4});
    tbl.push_back('{0,0,0,64'h0,   1,64'h8,   1,64'h4});
    tbl.push_back('{1,0,0,64'h0,   1,64'hc,   1,64'h8});
    tbl.push_back('{1,0,0,64'h0,   1,64'h10,  1,64'hc});
    tbl.push_back('{1,1,0,64'h0,   0,64'h14,  1,64'hc});
    tbl.push_back('{1,1,0,64'h0,   0,64'h14,  1,64'hc});
    tbl.push_back('{0,0,0,64'h0,   1,64'h14,  1,64'h10});
    tbl.push_back('{1,0,0,64'h0,   1,64'h18,  1,64'h14});
    tbl.push_back('{0,0,1,64'h40,  1,64'h18,  0,64'h0});
    tbl.push_back('{0,0,0,64'h0,   1,64'h18,  0,64'h0});
    tbl.push_back('{1,0,0,64'h0,   1,64'h40,  0,64'h0});
    tbl.push_back('{1,0,0,64'h0,   1,64'h44,  1,64'h40});
    tbl.push_back('{1,1,1,64'h103, 1,64'h100, 0,64'h0});
    tbl.push_back('{1,1,0,64'h0,   1,64'h104, 1,64'h100});
    tbl.push_back('{1,0,1,64'hffff_ffff_ffff_fffe, 1,64'hffff_ffff_ffff_fffc, 0,64'h0});
    tbl.push_back('{1,0,0,64'h0,   1,64'h0,   1,64'hffff_ffff_ffff_fffc});
    tbl.push_back('{1,0,0,64'h0,   1,64'h4,   1,64'h0});

    // Reset values
    @(negedge clk); @(negedge clk);
    chk("rst_req",   64'(imem_req),   64'h0);
    chk("rst_addr",  imem_addr,       64'h0);
    chk("rst_valid", 64'(ifid_valid), 64'h0);
    chk("rst_instr", 64'(ifid_instr), 64'h0);
    chk("rst_pc",    ifid_pc,         64'h0);
    rst_n = 1'b1;

    // Directed table
    foreach (tbl[i]) begin
      imem_ready    = tbl[i].rdy;
      stall         = tbl[i].st;
      branch_taken  = tbl[i].br;
      branch_target = tbl[i].tgt;
      imem_rdata    = rd_of(imem_addr);
      @(posedge clk); #1;
      chk($sformatf("v%0d_req", i),   64'(imem_req),   64'(tbl[i].e_req));
      chk($sformatf("v%0d_addr", i),  imem_addr,       tbl[i].e_addr);
      chk($sformatf("v%0d_valid", i), 64'(ifid_valid), 64'(tbl[i].e_v));
      if (tbl[i].e_v) begin
        exp_instr = rd_of(tbl[i].e_pc);
        exp_op    = exp_instr[31:21];
        chk($sformatf("v%0d_pc", i),     ifid_pc,          tbl[i].e_pc);
        chk($sformatf("v%0d_instr", i),  64'(ifid_instr),  64'(exp_instr));
        chk($sformatf("v%0d_opcode", i), 64'(ifid_opcode), 64'(exp_op));
      end
      @(negedge clk);
    end

    // Reset while a dropped request is outstanding
    imem_ready = 1'b0; stall = 1'b0; branch_taken = 1'b1; branch_target = 64'h200;
    @(posedge clk); #1;
    chk("drop_req",   64'(imem_req),   64'h1);
    chk("drop_addr",  imem_addr,       64'h4);
    chk("drop_valid", 64'(ifid_valid), 64'h0);
    branch_taken = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req",   64'(imem_req),   64'h0);
    chk("arst_valid", 64'(ifid_valid), 64'h0);
    chk("arst_addr",  imem_addr,       64'h0);
    @(negedge clk);
    rst_n = 1'b1; imem_ready = 1'b1; imem_rdata = rd_of(64'h0);
    @(posedge clk); #1;
    chk("post_req",  64'(imem_req), 64'h1);
    chk("post_addr", imem_addr,     64'h0);
    @(negedge clk);
    imem_rdata = rd_of(imem_addr);
    @(posedge clk); #1;
    chk("post_valid", 64'(ifid_valid), 64'h1);
    chk("post_pc",    ifid_pc,         64'h0);
    chk("post_addr2", imem_addr,       64'h4);
    @(negedge clk);

    // Randomized run against the reference model
    rst_n = 1'b0;
    imem_ready = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_req",   64'(imem_req),   64'(m_started && m_skid.size() == 0));
      chk("rnd_addr",  imem_addr,       m_pc);
      chk("rnd_valid", 64'(ifid_valid), 64'(m_v));
      if (m_v) begin
        exp_op = m_ifid.instr[31:21];
        chk("rnd_pc",     ifid_pc,          m_ifid.pc);
        chk("rnd_instr",  64'(ifid_instr),  64'(m_ifid.instr));
        chk("rnd_opcode", 64'(ifid_opcode), 64'(exp_op));
      end
      imem_ready    = ($urandom_range(0, 9) < 7);
      stall         = ($urandom_range(0, 9) < 3);
      branch_taken  = ($urandom_range(0, 19) < 2);
      branch_target = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) == 0) branch_target = 64'hffff_ffff_ffff_fff0 | 64'($urandom_range(0, 15));
      imem_rdata    = $urandom;
      model_step(branch_taken, branch_target, imem_ready, imem_rdata, stall);
      @(posedge clk);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
